// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the RV32I datapath.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             zero;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_write;
  logic             dmem_req;
  logic             dmem_we;
  logic [1:0]       alu_op;
  logic             alu_src;
  logic             reg_write;
  logic             mem_to_reg;
  logic             pc_write;
  logic             pc_src;
  logic             trap;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, zero, imem_ready, dmem_ready,
    output imem_req, ir_write, dmem_req, dmem_we, alu_op, alu_src,
           reg_write, mem_to_reg, pc_write, pc_src, trap, instret
  );

  modport slave (
    output opcode, zero, imem_ready, dmem_ready,
    input  imem_req, ir_write, dmem_req, dmem_we, alu_op, alu_src,
           reg_write, mem_to_reg, pc_write, pc_src, trap, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle RV32I core with memory-wait
// watchdog, absorbing trap state and retired-instruction counter.
module multicycle_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_controller_if.master ctl
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LIMIT = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : {WD_W{1'b0}};
  localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic       wd_expired_s;
  logic       imem_req_s, ir_write_s, dmem_req_s, dmem_we_s;
  logic [1:0] alu_op_s;
  logic       alu_src_s, reg_write_s, mem_to_reg_s, pc_write_s, pc_src_s, trap_s;

  assign wd_expired_s = (TIMEOUT != 0) && (wd_q == WD_LIMIT);

  // Next-state and control decode; every output defaults low.
  always_comb begin
    state_d      = state_q;
    imem_req_s   = 1'b0;
    ir_write_s   = 1'b0;
    dmem_req_s   = 1'b0;
    dmem_we_s    = 1'b0;
    alu_op_s     = 2'b00;
    alu_src_s    = 1'b0;
    reg_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    pc_write_s   = 1'b0;
    pc_src_s     = 1'b0;
    trap_s       = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_s = 1'b1;
        if (ctl.imem_ready) begin
          ir_write_s = 1'b1;
          state_d    = S_DECODE;
        end else if (wd_expired_s) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (ctl.opcode)
          OP_LW, OP_I, OP_SW, OP_R, OP_BEQ: state_d = S_EXEC;
          default:                          state_d = S_TRAP;
        endcase
      end
      S_EXEC: begin
        case (ctl.opcode)
          OP_LW, OP_SW: begin
            alu_op_s  = 2'b00;
            alu_src_s = 1'b1;
            state_d   = S_MEM;
          end
          OP_I: begin
            alu_op_s  = 2'b11;
            alu_src_s = 1'b1;
            state_d   = S_WB;
          end
          OP_R: begin
            alu_op_s  = 2'b10;
            alu_src_s = 1'b0;
            state_d   = S_WB;
          end
          OP_BEQ: begin
            alu_op_s   = 2'b01;
            alu_src_s  = 1'b0;
            pc_write_s = 1'b1;
            pc_src_s   = ctl.zero;
            state_d    = S_FETCH;
          end
          // IR is held by the datapath, so only a corrupted opcode lands here
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = (ctl.opcode == OP_SW);
        alu_op_s   = 2'b00;
        alu_src_s  = 1'b1;
        if (ctl.dmem_ready) begin
          if (ctl.opcode == OP_SW) begin
            pc_write_s = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wd_expired_s) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = (ctl.opcode == OP_LW);
        pc_write_s   = 1'b1;
        state_d      = S_FETCH;
      end
      S_TRAP: begin
        trap_s  = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_TRAP;
    endcase
  end

  // Watchdog counts only cycles spent re-waiting in FETCH or MEM; any entry restarts it.
  always_comb begin
    wd_d = {WD_W{1'b0}};
    if (((state_q == S_FETCH) || (state_q == S_MEM)) && (state_d == state_q)) begin
      wd_d = wd_q + WD_ONE;
    end else begin
      wd_d = {WD_W{1'b0}};
    end
    if (pc_write_s) begin
      instret_d = instret_q + CNT_ONE;
    end else begin
      instret_d = instret_q;
    end
  end

  // State, watchdog and retirement counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wd_q      <= {WD_W{1'b0}};
      instret_q <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      instret_q <= instret_d;
    end
  end

  // Held reset forces every strobe low, including the FETCH request.
  assign ctl.imem_req   = rst_n & imem_req_s;
  assign ctl.ir_write   = rst_n & ir_write_s;
  assign ctl.dmem_req   = rst_n & dmem_req_s;
  assign ctl.dmem_we    = rst_n & dmem_we_s;
  assign ctl.alu_op     = rst_n ? alu_op_s : 2'b00;
  assign ctl.alu_src    = rst_n & alu_src_s;
  assign ctl.reg_write  = rst_n & reg_write_s;
  assign ctl.mem_to_reg = rst_n & mem_to_reg_s;
  assign ctl.pc_write   = rst_n & pc_write_s;
  assign ctl.pc_src     = rst_n & pc_src_s;
  assign ctl.trap       = rst_n & trap_s;
  assign ctl.instret    = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench with a retirement scoreboard for multicycle_controller (TIMEOUT=16, CNT_W=4).
module tb_multicycle_controller;

  localparam int CNT_W = 4;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef struct {
    logic [6:0] opcode;
    logic       zero;
    int         idly;
    int         ddly;
    int         lat;
    logic       pc_src;
    logic [1:0] alu_op;
    logic       alu_src;
    int         rw;
    logic       m2r;
    int         dreq;
    logic       we;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_controller_if #(.CNT_W(CNT_W)) ctl ();

  multicycle_controller #(.TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (ctl)
  );

  int               n_tests = 0;
  int               n_fail  = 0;
  vec_t             exp_q[$];
  vec_t             tbl[9];
  logic [CNT_W-1:0] exp_instret;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {ctl.imem_req, ctl.ir_write, ctl.dmem_req, ctl.dmem_we, ctl.alu_op, ctl.alu_src,
            ctl.reg_write, ctl.mem_to_reg, ctl.pc_write, ctl.pc_src, ctl.trap};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    ctl.imem_ready = 1'b0;
    ctl.dmem_ready = 1'b0;
    #1;
    check("reset_outs", outs(), 12'h000);
    check("reset_instret", ctl.instret, 32'd0);
    @(posedge clk);
    #2;
    rst_n       = 1'b1;
    exp_instret = '0;
  endtask

  task automatic run_instr(input vec_t v);
    vec_t       e;
    int         cyc, rw, dreq, irw, icnt, dcnt;
    logic       m2r, we, asrc;
    logic [1:0] aop;
    bit         done;
    exp_q.push_back(v);
    cyc = 0; rw = 0; dreq = 0; irw = 0; icnt = 0; dcnt = 0;
    m2r = 1'b0; we = 1'b0; asrc = 1'b0; aop = 2'b00; done = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      ctl.opcode     = v.opcode;
      ctl.zero       = v.zero;
      ctl.imem_ready = 1'b0;
      ctl.dmem_ready = 1'b0;
      #1;
      if (c == 0) check("instret_pre", ctl.instret, exp_instret);
      if (ctl.imem_req) begin
        if (icnt == v.idly) ctl.imem_ready = 1'b1;
        else icnt++;
      end
      if (ctl.dmem_req) begin
        if (dcnt == v.ddly) ctl.dmem_ready = 1'b1;
        else dcnt++;
      end
      #1;
      cyc++;
      if (cyc == v.idly + 3) begin
        aop  = ctl.alu_op;
        asrc = ctl.alu_src;
      end
      irw  += int'(ctl.ir_write);
      rw   += int'(ctl.reg_write);
      dreq += int'(ctl.dmem_req);
      if (ctl.dmem_we) we = 1'b1;
      if (ctl.reg_write) m2r = ctl.mem_to_reg;
      if (ctl.pc_write) begin
        done = 1'b1;
        e = exp_q.pop_front();
        check("latency", cyc, e.lat);
        check("pc_src", ctl.pc_src, e.pc_src);
        check("alu_op", aop, e.alu_op);
        check("alu_src", asrc, e.alu_src);
        check("reg_write_cycles", rw, e.rw);
        check("mem_to_reg", m2r, e.m2r);
        check("dmem_req_cycles", dreq, e.dreq);
        check("dmem_we", we, e.we);
        check("ir_write_cycles", irw, 1);
        exp_instret = exp_instret + 1'b1;
      end
    end
    if (!done) begin
      e = exp_q.pop_front();
      check("retired", done, 1'b1);
    end
  endtask

  initial begin
    int   nreq, tcyc;
    bit   bad;
    vec_t add_v;

    tbl[0] = '{OP_R,   1'b0, 0,  0,  4,  1'b0, 2'b10, 1'b0, 1, 1'b0, 0,  1'b0};
    tbl[1] = '{OP_I,   1'b0, 0,  0,  4,  1'b0, 2'b11, 1'b1, 1, 1'b0, 0,  1'b0};
    tbl[2] = '{OP_BEQ, 1'b1, 0,  0,  3,  1'b1, 2'b01, 1'b0, 0, 1'b0, 0,  1'b0};
    tbl[3] = '{OP_BEQ, 1'b0, 0,  0,  3,  1'b0, 2'b01, 1'b0, 0, 1'b0, 0,  1'b0};
    tbl[4] = '{OP_LW,  1'b0, 0,  3,  8,  1'b0, 2'b00, 1'b1, 1, 1'b1, 4,  1'b0};
    tbl[5] = '{OP_SW,  1'b0, 0,  0,  4,  1'b0, 2'b00, 1'b1, 0, 1'b0, 1,  1'b1};
    tbl[6] = '{OP_SW,  1'b1, 2,  1,  7,  1'b0, 2'b00, 1'b1, 0, 1'b0, 2,  1'b1};
    tbl[7] = '{OP_LW,  1'b0, 15, 15, 35, 1'b0, 2'b00, 1'b1, 1, 1'b1, 16, 1'b0};
    tbl[8] = '{OP_R,   1'b1, 1,  0,  5,  1'b0, 2'b10, 1'b0, 1, 1'b0, 0,  1'b0};
    add_v  = tbl[0];

    rst_n          = 1'b0;
    ctl.opcode     = OP_R;
    ctl.zero       = 1'b0;
    ctl.imem_ready = 1'b0;
    ctl.dmem_ready = 1'b0;
    exp_instret    = '0;

    do_reset();
    #1;
    check("fetch_after_reset", ctl.imem_req, 1'b1);

    foreach (tbl[i]) run_instr(tbl[i]);

    // Seven more ADDs bring the total to sixteen retirements: the 4-bit counter wraps.
    for (int i = 0; i < 7; i++) run_instr(add_v);
    @(negedge clk);
    #1;
    check("instret_wrap", ctl.instret, 32'd0);

    // Reset asserted while an SW sits in MEM.
    do_reset();
    run_instr(add_v);
    nreq = 0;
    for (int c = 0; c < 12 && nreq < 3; c++) begin
      @(negedge clk);
      ctl.opcode     = OP_SW;
      ctl.imem_ready = 1'b1;
      ctl.dmem_ready = 1'b0;
      #1;
      if (ctl.dmem_req) nreq++;
      check("sw_no_retire", ctl.pc_write, 1'b0);
    end
    check("sw_in_mem", nreq, 3);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_outs", outs(), 12'h000);
    check("midreset_instret", ctl.instret, 32'd0);
    @(posedge clk);
    #2;
    rst_n          = 1'b1;
    ctl.imem_ready = 1'b0;
    exp_instret    = '0;
    #1;
    check("midreset_fetch", outs(), 12'h800);
    run_instr(add_v);

    // Illegal opcode traps after DECODE and stays trapped.
    do_reset();
    tcyc = 0;
    for (int c = 1; c <= 10 && tcyc == 0; c++) begin
      @(negedge clk);
      ctl.opcode     = OP_JAL;
      ctl.imem_ready = 1'b1;
      #1;
      if (ctl.trap) tcyc = c;
    end
    check("jal_trap_cycle", tcyc, 3);
    bad = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      ctl.imem_ready = c[0];
      ctl.dmem_ready = c[1];
      #1;
      if (outs() !== 12'h001 || ctl.instret !== 4'd0) bad = 1'b1;
    end
    check("trap_hold", bad, 1'b0);

    // Instruction fetch never answered: trap after sixteen waiting FETCH cycles.
    do_reset();
    nreq = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      ctl.imem_ready = 1'b0;
      #1;
      if (ctl.trap) break;
      nreq += int'(ctl.imem_req);
    end
    check("imem_timeout_cycles", nreq, 16);
    check("imem_timeout_trap", ctl.trap, 1'b1);

    // Data access never completes: trap after sixteen MEM cycles, nothing retires.
    do_reset();
    nreq = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      ctl.opcode     = OP_SW;
      ctl.imem_ready = 1'b1;
      ctl.dmem_ready = 1'b0;
      #1;
      if (ctl.trap) break;
      nreq += int'(ctl.dmem_req);
    end
    check("dmem_timeout_cycles", nreq, 16);
    check("dmem_timeout_trap", ctl.trap, 1'b1);
    check("dmem_timeout_instret", ctl.instret, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
